// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the fetch stage and the controller:
// widths, reset vector, the canonical NOP, fetch FSM states and opcodes.
package riscv_pkg;

   localparam int               XLEN      = 32;
   localparam logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000;
   localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus: req/gnt address phase,
// rvalid/rdata data phase, one transaction outstanding at a time.
interface instr_fetch_if #(
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata
   );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches one word at a time and holds it on
// instr/pc until execute accepts, then steps to PC+4 or the redirect target.
module instr_fetch #(
   parameter int              XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
   input  logic            clk,
   input  logic            rst_n,
   instr_fetch_if.master   imem,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            instr_valid,
   input  logic            instr_ready,
   input  logic            PCsel,
   input  logic [XLEN-1:0] alu_result,
   output logic            target_misaligned
);
   import riscv_pkg::*;

   fetch_state_t    state_q, state_d;
   logic            capture, accept;
   logic [XLEN-1:0] target;

   // JALR clears bit 0; bit 1 is flagged but still followed
   assign target   = {alu_result[XLEN-1:1], 1'b0};
   assign pc_plus4 = pc + XLEN'(4);

   assign imem.imem_req  = (state_q == REQ);
   assign imem.imem_addr = pc;

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      accept  = 1'b0;
      unique case (state_q)
         REQ:  if (imem.imem_gnt) state_d = WAIT;
         WAIT: if (imem.imem_rvalid) begin
                  capture = 1'b1;
                  state_d = HOLD;
               end
         HOLD: if (instr_ready) begin
                  accept  = 1'b1;
                  state_d = REQ;
               end
         default: state_d = REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= REQ;
         pc                <= RESET_PC;
         instr             <= XLEN'(NOP_INSTR);
         instr_valid       <= 1'b0;
         target_misaligned <= 1'b0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
         end
         // PCsel/alu_result only matter on the accept cycle
         if (accept) begin
            instr_valid <= 1'b0;
            pc          <= PCsel ? target : pc_plus4;
            if (PCsel && alu_result[1]) target_misaligned <= 1'b1;
         end
      end
   end

endmodule
